// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side VGA monitor. Samples H_SYNC/V_SYNC and 4-bit RGB on the pixel
//   clock and recovers the pixel position and display-enable. It checks sync
//   timing against the mode parameters, tracks a SEARCH/TRACK/LOCKED state and
//   produces a checksum of each frame's visible pixels.
//   All outputs are registered. Outputs in cycle n+2 describe the inputs sampled
//   in cycle n.
// Ports
//   vga_pix_clk         pixel clock
//   rst                 synchronous active-high reset
//   H_SYNC, V_SYNC      sync inputs, low-asserted when SYNC_ACTIVE_LOW != 0
//   R, G, B             4-bit colour components
//   rx_sx, rx_sy        recovered pixel coordinates
//   rx_de               visible-area enable (never in SEARCH)
//   frame_stb           one-cycle pulse at pixel (0,0) (never in SEARCH)
//   frame_sum           checksum of the previous frame's visible pixels
//   locked              state is LOCKED
//   h_err, v_err        one-cycle timing-violation pulses
//   err_count           saturating count of cycles with h_err or v_err
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE_AREA  = 640,
  parameter int unsigned H_FRONT_PORCH   = 16,
  parameter int unsigned H_SYNC_PULSE    = 96,
  parameter int unsigned H_BACK_PORCH    = 48,
  parameter int unsigned V_VISIBLE_AREA  = 480,
  parameter int unsigned V_FRONT_PORCH   = 10,
  parameter int unsigned V_SYNC_PULSE    = 2,
  parameter int unsigned V_BACK_PORCH    = 33,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned LOCK_FRAMES     = 2,
  localparam int unsigned H_WHOLE = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
  localparam int unsigned V_WHOLE = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
  localparam int unsigned H_ADDR_WIDTH = $clog2(H_WHOLE),
  localparam int unsigned V_ADDR_WIDTH = $clog2(V_WHOLE)
) (
  input  logic                    vga_pix_clk,
  input  logic                    rst,
  input  logic                    H_SYNC,
  input  logic                    V_SYNC,
  input  logic [3:0]              R,
  input  logic [3:0]              G,
  input  logic [3:0]              B,
  output logic [H_ADDR_WIDTH-1:0] rx_sx,
  output logic [V_ADDR_WIDTH-1:0] rx_sy,
  output logic                    rx_de,
  output logic                    frame_stb,
  output logic [15:0]             frame_sum,
  output logic                    locked,
  output logic                    h_err,
  output logic                    v_err,
  output logic [7:0]              err_count
);

  localparam logic [H_ADDR_WIDTH-1:0] H_LOAD  = H_ADDR_WIDTH'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [H_ADDR_WIDTH-1:0] H_PRE   = H_ADDR_WIDTH'(H_VISIBLE_AREA + H_FRONT_PORCH - 1);
  localparam logic [H_ADDR_WIDTH-1:0] H_LAST  = H_ADDR_WIDTH'(H_WHOLE - 1);
  localparam logic [H_ADDR_WIDTH-1:0] H_VIS   = H_ADDR_WIDTH'(H_VISIBLE_AREA);
  localparam logic [H_ADDR_WIDTH-1:0] H_PULSE = H_ADDR_WIDTH'(H_SYNC_PULSE);
  localparam logic [V_ADDR_WIDTH-1:0] V_LOAD  = V_ADDR_WIDTH'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [V_ADDR_WIDTH-1:0] V_LAST  = V_ADDR_WIDTH'(V_WHOLE - 1);
  localparam logic [V_ADDR_WIDTH-1:0] V_VIS   = V_ADDR_WIDTH'(V_VISIBLE_AREA);
  localparam logic [V_ADDR_WIDTH-1:0] V_PULSE = V_ADDR_WIDTH'(V_SYNC_PULSE);
  localparam logic                    SYNC_INV = (SYNC_ACTIVE_LOW != 0);
  localparam int unsigned             GOOD_W   = $clog2(LOCK_FRAMES + 2);
  localparam logic [GOOD_W-1:0]       GOOD_TGT = GOOD_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t                  state, state_nxt;
  logic                    hs1, hs2, vs1, vs2;
  logic [11:0]             pix1;
  logic [H_ADDR_WIDTH-1:0] hcnt, hcnt_nxt;
  logic [V_ADDR_WIDTH-1:0] vcnt, vcnt_inc, vcnt_nxt;
  logic [H_ADDR_WIDTH-1:0] hw, hw_nxt;    // samples seen with hsync asserted
  logic [V_ADDR_WIDTH-1:0] vhs, vhs_nxt;  // hsync rises seen with vsync asserted
  logic [GOOD_W-1:0]       good, good_nxt;
  logic [15:0]             acc;
  logic                    hs_rise, hs_fall, vs_rise, vs_fall;
  logic                    h_err_nxt, v_err_nxt, stb_pos, de_pos, stb_nxt, de_nxt;

  assign rx_sx = hcnt;
  assign rx_sy = vcnt;

  always_comb begin
    hs_rise = hs1 & ~hs2;
    hs_fall = ~hs1 & hs2;
    vs_rise = vs1 & ~vs2;
    vs_fall = ~vs1 & vs2;

    hcnt_nxt = (hcnt == H_LAST) ? '0 : hcnt + H_ADDR_WIDTH'(1);
    vcnt_inc = vcnt;
    if (hs_rise) begin
      hcnt_nxt = H_LOAD;
    end else if (hcnt == H_LAST) begin
      vcnt_inc = (vcnt == V_LAST) ? '0 : vcnt + V_ADDR_WIDTH'(1);
    end
    vcnt_nxt = vs_rise ? V_LOAD : vcnt_inc;

    hw_nxt = hw;
    if (hs_rise) begin
      hw_nxt = H_ADDR_WIDTH'(1);
    end else if (hs1 && hw != '1) begin
      hw_nxt = hw + H_ADDR_WIDTH'(1);
    end

    vhs_nxt = vhs;
    if (vs_rise) begin
      vhs_nxt = hs_rise ? V_ADDR_WIDTH'(1) : '0;
    end else if (vs1 && hs_rise && vhs != '1) begin
      vhs_nxt = vhs + V_ADDR_WIDTH'(1);
    end

    h_err_nxt = (state != SEARCH) &&
                ((hs_rise && hcnt != H_PRE) || (hs_fall && hw != H_PULSE));
    v_err_nxt = (state != SEARCH) &&
                ((vs_rise && vcnt_inc != V_LOAD) || (vs_fall && vhs != V_PULSE));

    stb_pos = (hcnt_nxt == '0) && (vcnt_nxt == '0);
    de_pos  = (hcnt_nxt < H_VIS) && (vcnt_nxt < V_VIS);

    state_nxt = state;
    good_nxt  = good;
    case (state)
      SEARCH: begin
        if (vs_rise) begin
          state_nxt = TRACK;
          good_nxt  = '0;
        end
      end
      TRACK: begin
        // Any error leaves TRACK, so every strobe seen here closes a clean frame.
        if (h_err_nxt || v_err_nxt) begin
          state_nxt = SEARCH;
        end else if (stb_pos) begin
          good_nxt = good + GOOD_W'(1);
          if (good_nxt >= GOOD_TGT) begin
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (h_err_nxt || v_err_nxt) begin
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase

    stb_nxt = stb_pos && (state_nxt != SEARCH);
    de_nxt  = de_pos && (state_nxt != SEARCH);
  end

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      hs1       <= 1'b0;
      hs2       <= 1'b0;
      vs1       <= 1'b0;
      vs2       <= 1'b0;
      pix1      <= '0;
      hcnt      <= '0;
      vcnt      <= '0;
      hw        <= '0;
      vhs       <= '0;
      good      <= '0;
      acc       <= '0;
      state     <= SEARCH;
      rx_de     <= 1'b0;
      frame_stb <= 1'b0;
      frame_sum <= '0;
      locked    <= 1'b0;
      h_err     <= 1'b0;
      v_err     <= 1'b0;
      err_count <= '0;
    end else begin
      hs1       <= H_SYNC ^ SYNC_INV;
      vs1       <= V_SYNC ^ SYNC_INV;
      hs2       <= hs1;
      vs2       <= vs1;
      pix1      <= {R, G, B};
      hcnt      <= hcnt_nxt;
      vcnt      <= vcnt_nxt;
      hw        <= hw_nxt;
      vhs       <= vhs_nxt;
      good      <= good_nxt;
      state     <= state_nxt;
      rx_de     <= de_nxt;
      frame_stb <= stb_nxt;
      locked    <= (state_nxt == LOCKED);
      h_err     <= h_err_nxt;
      v_err     <= v_err_nxt;
      if ((h_err_nxt || v_err_nxt) && err_count != '1) begin
        err_count <= err_count + 8'd1;
      end
      // pix1 is the pixel that hcnt_nxt/vcnt_nxt describe, so the strobe
      // pixel seeds the new sum instead of closing the old one.
      if (state_nxt == SEARCH) begin
        acc <= '0;
      end else if (stb_nxt) begin
        frame_sum <= acc;
        acc       <= de_nxt ? {4'b0, pix1} : '0;
      end else if (de_nxt) begin
        acc <= acc + {4'b0, pix1};
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
//   Drives a reduced 16x8 mode (H 16/2/4/3 = 25, V 8/2/2/3 = 15) into two
//   decoder instances: one with low-asserted syncs, one with high-asserted
//   syncs fed the inverted waveform. Expected values are hand-computed.
module tb_vga_sync_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       H_SYNC_a, V_SYNC_a, H_SYNC_b, V_SYNC_b;
  logic [3:0] R, G, B;

  logic [4:0]  rx_sx_a, rx_sx_b;
  logic [3:0]  rx_sy_a, rx_sy_b;
  logic        rx_de_a, rx_de_b, frame_stb_a, frame_stb_b;
  logic [15:0] frame_sum_a, frame_sum_b;
  logic        locked_a, locked_b, h_err_a, h_err_b, v_err_a, v_err_b;
  logic [7:0]  err_count_a, err_count_b;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_VISIBLE_AREA(16), .H_FRONT_PORCH(2), .H_SYNC_PULSE(4), .H_BACK_PORCH(3),
    .V_VISIBLE_AREA(8),  .V_FRONT_PORCH(2), .V_SYNC_PULSE(2), .V_BACK_PORCH(3),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut_a (
    .vga_pix_clk(clk), .rst(rst), .H_SYNC(H_SYNC_a), .V_SYNC(V_SYNC_a),
    .R(R), .G(G), .B(B),
    .rx_sx(rx_sx_a), .rx_sy(rx_sy_a), .rx_de(rx_de_a), .frame_stb(frame_stb_a),
    .frame_sum(frame_sum_a), .locked(locked_a), .h_err(h_err_a), .v_err(v_err_a),
    .err_count(err_count_a)
  );

  vga_sync_decoder #(
    .H_VISIBLE_AREA(16), .H_FRONT_PORCH(2), .H_SYNC_PULSE(4), .H_BACK_PORCH(3),
    .V_VISIBLE_AREA(8),  .V_FRONT_PORCH(2), .V_SYNC_PULSE(2), .V_BACK_PORCH(3),
    .SYNC_ACTIVE_LOW(0), .LOCK_FRAMES(2)
  ) dut_b (
    .vga_pix_clk(clk), .rst(rst), .H_SYNC(H_SYNC_b), .V_SYNC(V_SYNC_b),
    .R(R), .G(G), .B(B),
    .rx_sx(rx_sx_b), .rx_sy(rx_sy_b), .rx_de(rx_de_b), .frame_stb(frame_stb_b),
    .frame_sum(frame_sum_b), .locked(locked_b), .h_err(h_err_b), .v_err(v_err_b),
    .err_count(err_count_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Generator position of the pixel sampled one and two edges ago.
  int d1x = -1, d1y = -1, d2x = -1, d2y = -1;
  int frame_no = -1;
  logic chk_coords = 1'b0;
  logic count_de = 1'b0;
  int de_cnt = 0;

  int herr_n = 0, herr_x = -1, herr_y = -1;
  int verr_n = 0, verr_x = -1, verr_y = -1;
  int lock_rise_frame_a = -1, lock_rise_frame_b = -1;
  logic lock_rise_stb_a = 1'b0;
  logic lock_fall_ok = 1'b0;
  logic lk_prev_a = 1'b0, lk_prev_b = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive one generator pixel (sync levels given active-high), clock it in and
  // observe the outputs, which then describe the pixel driven one call earlier.
  task automatic pix(input int x, input int y, input logic hs, input logic vs,
                     input logic [11:0] rgb);
    H_SYNC_a = ~hs;
    V_SYNC_a = ~vs;
    H_SYNC_b = hs;
    V_SYNC_b = vs;
    {R, G, B} = rgb;
    @(posedge clk);
    #1;
    d2x = d1x; d2y = d1y;
    d1x = x;   d1y = y;
    if (h_err_a) begin herr_n++; herr_x = d2x; herr_y = d2y; end
    if (v_err_a) begin verr_n++; verr_x = d2x; verr_y = d2y; end
    if (locked_a && !lk_prev_a) begin
      lock_rise_frame_a = frame_no;
      lock_rise_stb_a   = frame_stb_a;
    end
    if (!locked_a && lk_prev_a) lock_fall_ok = h_err_a | v_err_a;
    if (locked_b && !lk_prev_b) lock_rise_frame_b = frame_no;
    lk_prev_a = locked_a;
    lk_prev_b = locked_b;
    if (count_de && rx_de_a) de_cnt++;
    if (chk_coords) begin
      check_eq("sx_a", 32'(rx_sx_a), d2x);
      check_eq("sy_a", 32'(rx_sy_a), d2y);
      check_eq("de_a", 32'(rx_de_a), 32'(d2x < 16 && d2y < 8));
      check_eq("sx_b", 32'(rx_sx_b), d2x);
      check_eq("sy_b", 32'(rx_sy_b), d2y);
      check_eq("de_b", 32'(rx_de_b), 32'(d2x < 16 && d2y < 8));
    end
  endtask

  task automatic reset_checks();
    check_eq("rst_sx",     32'(rx_sx_a), 0);
    check_eq("rst_sy",     32'(rx_sy_a), 0);
    check_eq("rst_de",     32'(rx_de_a), 0);
    check_eq("rst_stb",    32'(frame_stb_a), 0);
    check_eq("rst_sum",    32'(frame_sum_a), 0);
    check_eq("rst_locked", 32'(locked_a), 0);
    check_eq("rst_herr",   32'(h_err_a), 0);
    check_eq("rst_verr",   32'(v_err_a), 0);
    check_eq("rst_errcnt", 32'(err_count_a), 0);
    check_eq("rst_locked_b", 32'(locked_b), 0);
    check_eq("rst_errcnt_b", 32'(err_count_b), 0);
  endtask

  // One 15-line frame. short_line gets a 3-cycle hsync, long_line gets 26
  // pixels, vsync covers vs_lines lines from line 10, and rst is pulsed for one
  // cycle at pixel (5, rst_line).
  task automatic frame(input int vs_lines, input logic [11:0] rgb, input int short_line,
                       input int long_line, input int rst_line);
    frame_no++;
    for (int y = 0; y < 15; y++) begin
      for (int x = 0; x < ((y == long_line) ? 26 : 25); x++) begin
        if (y == rst_line && x == 5) rst = 1'b1;
        pix(x, y, (x >= 18) && (x < 18 + ((y == short_line) ? 3 : 4)),
            (y >= 10) && (y < 10 + vs_lines), (x < 16 && y < 8) ? rgb : 12'h000);
        if (rst) begin
          reset_checks();
          rst = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) pix(-1, -1, 1'b0, 1'b0, 12'h000);
    reset_checks();
    rst = 1'b0;
    pix(-1, -1, 1'b0, 1'b0, 12'h000);

    // Acquire and lock on an ideal generator.
    frame(2, 12'h123, -1, -1, -1);
    chk_coords = 1'b1;
    count_de   = 1'b1;
    frame(2, 12'h123, -1, -1, -1);
    count_de   = 1'b0;
    check_eq("de_per_frame", de_cnt, 128);
    check_eq("sum_first_stb", 32'(frame_sum_a), 0);
    frame(2, 12'h123, -1, -1, -1);
    chk_coords = 1'b0;
    check_eq("lock_frame_a", lock_rise_frame_a, 2);
    check_eq("lock_with_stb", 32'(lock_rise_stb_a), 1);
    check_eq("lock_frame_b", lock_rise_frame_b, 2);

    // Checksums: 128 pixels x colour, modulo 2^16.
    frame(2, 12'hFFF, -1, -1, -1);
    check_eq("sum_123_a", 32'(frame_sum_a), 32'h9180);
    check_eq("sum_123_b", 32'(frame_sum_b), 32'h9180);
    frame(2, 12'h001, -1, -1, -1);
    check_eq("sum_fff_wrap", 32'(frame_sum_a), 32'hFF80);
    frame(2, 12'h123, -1, -1, -1);
    check_eq("sum_001", 32'(frame_sum_a), 32'h0080);
    check_eq("locked_steady", 32'(locked_a), 1);
    check_eq("errcnt_clean", 32'(err_count_a), 0);

    // Short hsync pulse on line 2: error at its falling edge (x=21).
    frame(2, 12'h123, 2, -1, -1);
    check_eq("herr_short_n", herr_n, 1);
    check_eq("herr_short_x", herr_x, 21);
    check_eq("herr_short_y", herr_y, 2);
    check_eq("lock_fall_at_err", 32'(lock_fall_ok), 1);
    check_eq("errcnt_1", 32'(err_count_a), 1);
    check_eq("unlocked_after_err", 32'(locked_a), 0);
    check_eq("verr_none", verr_n, 0);
    frame(2, 12'h123, -1, -1, -1);
    frame(2, 12'h123, -1, -1, -1);
    check_eq("relock_frame", lock_rise_frame_a, 8);
    check_eq("relocked", 32'(locked_a), 1);

    // 26-pixel line 3: error at the next hsync rise (18,4).
    frame(2, 12'h123, -1, 3, -1);
    check_eq("herr_long_n", herr_n, 2);
    check_eq("herr_long_x", herr_x, 18);
    check_eq("herr_long_y", herr_y, 4);
    check_eq("errcnt_2", 32'(err_count_a), 2);

    // Three-line vsync: error at its falling edge (0,13).
    frame(3, 12'h123, -1, -1, -1);
    check_eq("verr_n", verr_n, 1);
    check_eq("verr_x", verr_x, 0);
    check_eq("verr_y", verr_y, 13);
    check_eq("herr_still_2", herr_n, 2);
    check_eq("errcnt_3", 32'(err_count_a), 3);
    check_eq("errcnt_3_b", 32'(err_count_b), 3);

    // One-cycle vsync pulses: each rise enters TRACK, each fall has no hsync
    // rises behind it, so every pulse costs exactly one v_err.
    for (int i = 0; i < 252; i++) begin
      pix(-1, -1, 1'b0, 1'b1, 12'h000);
      pix(-1, -1, 1'b0, 1'b0, 12'h000);
    end
    repeat (2) pix(-1, -1, 1'b0, 1'b0, 12'h000);
    check_eq("errcnt_reach_255", 32'(err_count_a), 255);
    check_eq("verr_n_253", verr_n, 253);
    for (int i = 0; i < 48; i++) begin
      pix(-1, -1, 1'b0, 1'b1, 12'h000);
      pix(-1, -1, 1'b0, 1'b0, 12'h000);
    end
    repeat (2) pix(-1, -1, 1'b0, 1'b0, 12'h000);
    check_eq("errcnt_sat", 32'(err_count_a), 255);
    check_eq("errcnt_sat_b", 32'(err_count_b), 255);
    check_eq("verr_n_301", verr_n, 301);

    frame(2, 12'h123, -1, -1, -1);
    frame(2, 12'h123, -1, -1, -1);
    frame(2, 12'h123, -1, -1, -1);
    check_eq("lock_after_burst", lock_rise_frame_a, 13);

    // Mid-frame reset, then reacquire; the partial sum must not leak out.
    frame(2, 12'h123, -1, -1, 3);
    frame(2, 12'h001, -1, -1, -1);
    check_eq("sum_after_rst", 32'(frame_sum_a), 0);
    check_eq("locked_track", 32'(locked_a), 0);
    frame(2, 12'h123, -1, -1, -1);
    check_eq("sum_post_rst", 32'(frame_sum_a), 32'h0080);
    check_eq("lock_post_rst", lock_rise_frame_a, 16);
    check_eq("errcnt_post_rst", 32'(err_count_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
